// File: rtl/execute_stage.sv
// ============================================================================
// execute_stage
// ----------------------------------------------------------------------------
// Execute stage of the SimpleARM pipeline. Operands and opcode from decode go
// straight out to the external combinational ALU. The ALU result and NZCV
// flags come back and are registered into the EX/MEM pipeline register, which
// uses a valid/ready handshake. The stage also holds the architectural APSR
// flags. MULS runs on a fixed-latency shift-and-add multiplier that takes
// 32 iterations.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       handshake from decode
//   in_op_a, in_op_b          source operands
//   in_alu_op                 ALU opcode (ignored when in_is_mul)
//   in_is_mul                 instruction is a multiply
//   in_set_flags              update APSR when the instruction completes
//   in_rd, in_wb_en           destination register and write enable
//   alu_a, alu_b, alu_op      passthrough to the external ALU
//   alu_result, alu_n/z/c/v   result and flags back from the ALU
//   flush                     branch redirect, kills in-flight work
//   out_valid / out_ready     handshake to the memory stage
//   out_result, out_rd,
//   out_wb_en                 EX/MEM register contents
//   apsr_nzcv                 architectural flags {N,Z,C,V}
// ============================================================================
module execute_stage #(
   parameter logic [3:0] RESET_NZCV = 4'b0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_op_a,
   input  logic [31:0] in_op_b,
   input  logic [3:0]  in_alu_op,
   input  logic        in_is_mul,
   input  logic        in_set_flags,
   input  logic [3:0]  in_rd,
   input  logic        in_wb_en,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [3:0]  out_rd,
   output logic        out_wb_en,
   output logic [3:0]  apsr_nzcv
);

   typedef enum logic {RUN, MUL} state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [5:0]  cnt;
   logic [3:0]  mul_rd;
   logic        mul_wb_en;
   logic        mul_set_flags;

   logic        accept;
   logic        consume;
   logic        mul_done;
   logic [31:0] acc_step;

   // The ALU is fed straight from decode every cycle. A multiply ignores the
   // ALU result, so there is no need to gate these.
   assign alu_a  = in_op_a;
   assign alu_b  = in_op_b;
   assign alu_op = in_alu_op;

   // The stage takes a new instruction only in RUN, and only when the output
   // register is empty or is being drained this cycle. Because a multiply
   // can only start when the output is free, out_valid is always low while
   // the multiplier runs.
   assign in_ready = (state == RUN) && !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready && !flush;
   assign consume  = out_valid && out_ready;

   // This is one shift-and-add step. The value it produces on the 32nd step
   // is the final product, so completion can register it directly.
   assign acc_step = acc + (mplier[0] ? mcand : 32'd0);

   // Next-state logic. The multiplier finishes on the edge where cnt goes
   // from 31 to 32. A flush forces RUN, which abandons any multiply in
   // progress.
   always_comb begin
      state_next = state;
      mul_done   = 1'b0;
      case (state)
         RUN: begin
            if (accept && in_is_mul) begin
               state_next = MUL;
            end
         end
         MUL: begin
            if (cnt == 6'd31) begin
               state_next = RUN;
               mul_done   = 1'b1;
            end
         end
         default: state_next = RUN;
      endcase
      if (flush) begin
         state_next = RUN;
         mul_done   = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // This block holds the datapath: the EX/MEM register, APSR and the
   // multiplier registers. A flush only drops out_valid. It leaves the data
   // and flags alone, so a killed instruction never reaches APSR. A consume
   // clears the valid bit but leaves the data in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_result    <= 32'd0;
         out_rd        <= 4'd0;
         out_wb_en     <= 1'b0;
         apsr_nzcv     <= RESET_NZCV;
         acc           <= 32'd0;
         mcand         <= 32'd0;
         mplier        <= 32'd0;
         cnt           <= 6'd0;
         mul_rd        <= 4'd0;
         mul_wb_en     <= 1'b0;
         mul_set_flags <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else begin
         if (consume) begin
            out_valid <= 1'b0;
         end

         if (accept && !in_is_mul) begin
            out_result <= alu_result;
            out_rd     <= in_rd;
            out_wb_en  <= in_wb_en;
            out_valid  <= 1'b1;
            if (in_set_flags) begin
               apsr_nzcv <= {alu_n, alu_z, alu_c, alu_v};
            end
         end

         if (accept && in_is_mul) begin
            acc           <= 32'd0;
            mcand         <= in_op_a;
            mplier        <= in_op_b;
            cnt           <= 6'd0;
            mul_rd        <= in_rd;
            mul_wb_en     <= in_wb_en;
            mul_set_flags <= in_set_flags;
         end

         if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
            if (mul_done) begin
               out_result <= acc_step;
               out_rd     <= mul_rd;
               out_wb_en  <= mul_wb_en;
               out_valid  <= 1'b1;
               if (mul_set_flags) begin
                  apsr_nzcv <= {acc_step[31], (acc_step == 32'd0), apsr_nzcv[1:0]};
               end
            end
         end
      end
   end

endmodule
